// File: rtl/lifo_stack_pkg.sv
// rtl/lifo_stack_pkg.sv - shared types and helpers for the LIFO stack
package lifo_stack_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

  // Bit width needed to index/hold n values; never narrower than one bit.
  function automatic int clog2_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Requests that would overflow or underflow decode to OP_IDLE; the
  // error flags are raised separately by the caller.
  function automatic op_e decode_op(input logic push, input logic pop,
                                    input logic empty, input logic full);
    if (push && pop)
      return empty ? OP_PUSH : OP_REPLACE;
    else if (push)
      return full ? OP_IDLE : OP_PUSH;
    else if (pop)
      return empty ? OP_IDLE : OP_POP;
    else
      return OP_IDLE;
  endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// rtl/lifo_stack_mem.sv - stack storage, one write port and two async read ports
module lifo_stack_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  CLK,
  input  logic                  WR_EN,
  input  logic [PTR_W-1:0]      WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic [PTR_W-1:0]      RD_ADDR_TOP,
  input  logic [PTR_W-1:0]      RD_ADDR_NEXT,
  output logic [DATA_WIDTH-1:0] RD_DATA_TOP,
  output logic [DATA_WIDTH-1:0] RD_DATA_NEXT
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset; only occupied slots are ever read out.
  always_ff @(posedge CLK) begin
    if (WR_EN)
      mem[WR_ADDR] <= WR_DATA;
  end

  assign RD_DATA_TOP  = mem[RD_ADDR_TOP];
  assign RD_DATA_NEXT = mem[RD_ADDR_NEXT];

endmodule

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO with peek, replace, thresholds and sticky errors
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  DEPTH      = 4,
  parameter int  AF_THRESH  = DEPTH - 1,
  parameter int  AE_THRESH  = 1,
  localparam int PTR_W      = clog2_w(DEPTH),
  localparam int CNT_W      = clog2_w(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  CLR_ERR,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VALID,
  output logic [DATA_WIDTH-1:0] TOP,
  output logic [CNT_W-1:0]      COUNT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  op_e                   op;
  logic                  ovf_evt;
  logic                  unf_evt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [PTR_W-1:0]      top_ptr;
  logic [PTR_W-1:0]      next_ptr;
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_addr;
  logic [DATA_WIDTH-1:0] rd_top;
  logic [DATA_WIDTH-1:0] rd_next;

  // COUNT always mirrors FULL/EMPTY, so the registered flags drive the decode.
  assign op      = decode_op(PUSH, POP, EMPTY, FULL);
  assign ovf_evt = PUSH && !POP && FULL;
  assign unf_evt = POP && !PUSH && EMPTY;

  // Slot addresses wrap harmlessly when the stack is shallow; those reads are discarded.
  assign top_ptr  = PTR_W'(COUNT - CNT_W'(1));
  assign next_ptr = PTR_W'(COUNT - CNT_W'(2));

  assign wr_en   = RST_N && (op == OP_PUSH || op == OP_REPLACE);
  assign wr_addr = (op == OP_REPLACE) ? top_ptr : PTR_W'(COUNT);

  lifo_stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .CLK          (CLK),
    .WR_EN        (wr_en),
    .WR_ADDR      (wr_addr),
    .WR_DATA      (DATA_IN),
    .RD_ADDR_TOP  (top_ptr),
    .RD_ADDR_NEXT (next_ptr),
    .RD_DATA_TOP  (rd_top),
    .RD_DATA_NEXT (rd_next)
  );

  // Next occupancy; replace and the error cases leave it unchanged.
  always_comb begin
    cnt_nxt = COUNT;
    case (op)
      OP_PUSH: cnt_nxt = COUNT + CNT_W'(1);
      OP_POP:  cnt_nxt = COUNT - CNT_W'(1);
      default: cnt_nxt = COUNT;
    endcase
  end

  // Occupancy, status flags, peek, popped data and sticky errors.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      COUNT        <= '0;
      TOP          <= '0;
      DATA_OUT     <= '0;
      DATA_VALID   <= 1'b0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= (AF_THRESH == 0);
      ALMOST_EMPTY <= 1'b1;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      COUNT        <= cnt_nxt;
      FULL         <= (cnt_nxt == DEPTH_C);
      EMPTY        <= (cnt_nxt == '0);
      ALMOST_FULL  <= (cnt_nxt >= AF_C);
      ALMOST_EMPTY <= (cnt_nxt <= AE_C);
      DATA_VALID   <= 1'b0;
      case (op)
        OP_PUSH: TOP <= DATA_IN;
        OP_POP: begin
          DATA_OUT   <= rd_top;
          DATA_VALID <= 1'b1;
          TOP        <= (COUNT == CNT_W'(1)) ? '0 : rd_next;
        end
        OP_REPLACE: begin
          DATA_OUT   <= rd_top;
          DATA_VALID <= 1'b1;
          TOP        <= DATA_IN;
        end
        default: ;
      endcase
      if (ovf_evt)
        OVERFLOW <= 1'b1;
      else if (CLR_ERR)
        OVERFLOW <= 1'b0;
      if (unf_evt)
        UNDERFLOW <= 1'b1;
      else if (CLR_ERR)
        UNDERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - directed and random checks of lifo_stack against a queue model
module tb_lifo_stack;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic          CLK;
  logic          RST_N;
  logic          PUSH;
  logic          POP;
  logic [DW-1:0] DATA_IN;
  logic          CLR_ERR;
  logic [DW-1:0] DATA_OUT;
  logic          DATA_VALID;
  logic [DW-1:0] TOP;
  logic [2:0]    COUNT;
  logic          FULL;
  logic          EMPTY;
  logic          ALMOST_FULL;
  logic          ALMOST_EMPTY;
  logic          OVERFLOW;
  logic          UNDERFLOW;

  lifo_stack #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .PUSH         (PUSH),
    .POP          (POP),
    .DATA_IN      (DATA_IN),
    .CLR_ERR      (CLR_ERR),
    .DATA_OUT     (DATA_OUT),
    .DATA_VALID   (DATA_VALID),
    .TOP          (TOP),
    .COUNT        (COUNT),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int            vectors = 0;
  int            errors  = 0;
  logic [DW-1:0] stk[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] e_dout = '0;
  logic          e_dv   = 1'b0;
  logic          e_ovf  = 1'b0;
  logic          e_unf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = stk.size();
    chk("count", 32'(COUNT), 32'(n));
    chk("top", 32'(TOP), (n > 0) ? 32'(stk[n-1]) : 32'd0);
    chk("full", 32'(FULL), 32'(n == DEPTH));
    chk("empty", 32'(EMPTY), 32'(n == 0));
    chk("almost_full", 32'(ALMOST_FULL), 32'(n >= AF));
    chk("almost_empty", 32'(ALMOST_EMPTY), 32'(n <= AE));
    chk("overflow", 32'(OVERFLOW), 32'(e_ovf));
    chk("underflow", 32'(UNDERFLOW), 32'(e_unf));
    chk("data_valid", 32'(DATA_VALID), 32'(e_dv));
    if (DATA_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        e_dout = sb.pop_front();
      end
    end
    chk("data_out", 32'(DATA_OUT), 32'(e_dout));
  endtask

  // One cycle of stimulus: predict with the queue model, clock, then compare.
  task automatic do_op(input logic p, input logic q, input logic [DW-1:0] d, input logic clr);
    int   n;
    logic set_ovf;
    logic set_unf;
    PUSH = p; POP = q; DATA_IN = d; CLR_ERR = clr;
    n = stk.size();
    set_ovf = 1'b0;
    set_unf = 1'b0;
    e_dv = 1'b0;
    if (p && q && n > 0) begin
      sb.push_back(stk[n-1]);
      stk[n-1] = d;
      e_dv = 1'b1;
    end else if (p) begin
      if (n < DEPTH) stk.push_back(d);
      else set_ovf = 1'b1;
    end else if (q) begin
      if (n > 0) begin
        sb.push_back(stk.pop_back());
        e_dv = 1'b1;
      end else set_unf = 1'b1;
    end
    e_ovf = set_ovf ? 1'b1 : (clr ? 1'b0 : e_ovf);
    e_unf = set_unf ? 1'b1 : (clr ? 1'b0 : e_unf);
    @(posedge CLK);
    #1;
    PUSH = 1'b0; POP = 1'b0; CLR_ERR = 1'b0;
    check_all();
  endtask

  task automatic reset_model();
    stk.delete();
    sb.delete();
    e_dout = '0;
    e_dv   = 1'b0;
    e_ovf  = 1'b0;
    e_unf  = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; PUSH = 1'b0; POP = 1'b0; DATA_IN = '0; CLR_ERR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    reset_model();
    check_all();
    RST_N = 1'b1;

    // Fill to FULL, then overflow.
    do_op(1, 0, 8'h11, 0);
    do_op(1, 0, 8'h22, 0);
    do_op(1, 0, 8'h33, 0);
    do_op(1, 0, 8'h44, 0);
    do_op(1, 0, 8'h55, 0);
    // Overflow while clearing: the set wins.
    do_op(1, 0, 8'h66, 1);
    // Drain completely, then underflow, then clear both errors.
    do_op(0, 1, 8'h00, 0);
    do_op(0, 1, 8'h00, 0);
    do_op(0, 1, 8'h00, 0);
    do_op(0, 1, 8'h00, 0);
    do_op(0, 1, 8'h00, 0);
    do_op(0, 0, 8'h00, 1);

    // Replace at COUNT=2 and at FULL.
    do_op(1, 0, 8'h11, 0);
    do_op(1, 0, 8'h22, 0);
    do_op(1, 1, 8'h99, 0);
    do_op(1, 0, 8'h33, 0);
    do_op(1, 0, 8'h44, 0);
    do_op(1, 1, 8'hAA, 0);
    do_op(0, 0, 8'h00, 0);
    repeat (4) do_op(0, 1, 8'h00, 0);

    // Push+pop on empty acts as a plain push.
    do_op(1, 1, 8'h7E, 0);
    do_op(0, 1, 8'h00, 0);

    // Reset in the middle of a push.
    do_op(1, 0, 8'hA1, 0);
    do_op(1, 0, 8'hA2, 0);
    do_op(1, 0, 8'hA3, 0);
    RST_N = 1'b0; PUSH = 1'b1; DATA_IN = 8'hA4;
    @(posedge CLK);
    #1;
    RST_N = 1'b1; PUSH = 1'b0;
    reset_model();
    check_all();
    do_op(0, 1, 8'h00, 0);
    do_op(0, 0, 8'h00, 1);

    // Random mix.
    for (int i = 0; i < 60; i++) begin
      logic          rp;
      logic          rq;
      logic          rc;
      logic [DW-1:0] rd;
      rp = 1'($urandom_range(0, 1));
      rq = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 7) == 0);
      rd = 8'($urandom_range(0, 255));
      do_op(rp, rq, rd, rc);
    end

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
